// File: rtl/fas_pkg.sv
// Shared definitions for the FFT frame packer: frame geometry, the complex
// bin type and the 4-bit bit-reverse index mapping.
package fas_pkg;

  localparam int NPT    = 16;
  localparam int CW     = 32;
  localparam int FRAMES = 64;

  // Complex bin as delivered by the FFT core: real part in the upper half.
  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } cplx_t;

  // Reverse the bit order of a 4-bit bin index (k=1 -> 8, k=3 -> 12).
  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_pack_addr.sv
// Slot tracking for the frame packer. Counts accepted bins 0..15, decides
// whether an accept completes a frame or aborts a short one, and maps the
// slot to a write index. Build option: FFT_BITREV_EN selects bit-reversed
// placement of bins; when undefined bins are placed in natural order.
module fft_pack_addr
  import fas_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       last,
  output logic [3:0] slot,
  output logic [3:0] wr_idx,
  output logic       frame_done,
  output logic       short_err
);

  logic [3:0] slot_q;

  assign slot = slot_q;

  // A frame completes on the accept at slot 15 regardless of in_last;
  // an early in_last aborts the partial frame.
  assign frame_done = accept && (slot_q == 4'd15);
  assign short_err  = accept && last && (slot_q != 4'd15);

`ifdef FFT_BITREV_EN
  assign wr_idx = bitrev4(slot_q);
`else
  assign wr_idx = slot_q;
`endif

  // Slot counter: advance on accept, wrap at completion, clear on short frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= 4'd0;
    end else if (accept) begin
      if (frame_done || short_err) begin
        slot_q <= 4'd0;
      end else begin
        slot_q <= slot_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/fft_frame_packer.sv
// Assembles serial FFT bins into a 16-bin parallel frame with a one-cycle
// fft_valid strobe and enforces a per-run frame budget. Build option:
// FFT_BITREV_EN (bit-reversed bin placement, handled in fft_pack_addr).
//
// Input handshake: a word transfers on a rising edge where in_valid and
// in_ready are both high; in_ready only depends on registered state, and
// in_data/in_last are only looked at during a transfer.
module fft_frame_packer
  import fas_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_data,
  input  logic          in_last,
  output logic [CW-1:0] fft_d0,
  output logic [CW-1:0] fft_d1,
  output logic [CW-1:0] fft_d2,
  output logic [CW-1:0] fft_d3,
  output logic [CW-1:0] fft_d4,
  output logic [CW-1:0] fft_d5,
  output logic [CW-1:0] fft_d6,
  output logic [CW-1:0] fft_d7,
  output logic [CW-1:0] fft_d8,
  output logic [CW-1:0] fft_d9,
  output logic [CW-1:0] fft_d10,
  output logic [CW-1:0] fft_d11,
  output logic [CW-1:0] fft_d12,
  output logic [CW-1:0] fft_d13,
  output logic [CW-1:0] fft_d14,
  output logic [CW-1:0] fft_d15,
  output logic          fft_valid,
  output logic          frame_err,
  output logic          run_done
);

  localparam logic [6:0] FRAMES_C = 7'(FRAMES);

  logic       accept;
  logic [3:0] slot;
  logic [3:0] wr_idx;
  logic       frame_done;
  logic       short_err;

  cplx_t      fill_q [NPT];
  cplx_t      out_q  [NPT];
  logic [6:0] frame_cnt_q;
  logic       fft_valid_q;
  logic       frame_err_q;

  assign run_done = (frame_cnt_q == FRAMES_C);
  assign in_ready = !run_done;
  assign accept   = in_valid && in_ready;

  fft_pack_addr u_addr (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .last       (in_last),
    .slot       (slot),
    .wr_idx     (wr_idx),
    .frame_done (frame_done),
    .short_err  (short_err)
  );

  // Fill buffer: store each accepted bin except the one dropped by a short frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPT; i++) fill_q[i] <= '0;
    end else if (accept && !short_err) begin
      fill_q[wr_idx] <= cplx_t'(in_data);
    end
  end

  // Output registers: on completion take the 15 buffered bins plus the live word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPT; i++) out_q[i] <= '0;
    end else if (frame_done) begin
      for (int i = 0; i < NPT; i++) begin
        out_q[i] <= (4'(i) == wr_idx) ? cplx_t'(in_data) : fill_q[i];
      end
    end
  end

  // Strobes and the saturating frame counter that closes the input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fft_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 7'd0;
    end else begin
      fft_valid_q <= frame_done;
      frame_err_q <= short_err;
      if (frame_done && (frame_cnt_q != FRAMES_C)) begin
        frame_cnt_q <= frame_cnt_q + 7'd1;
      end
    end
  end

  assign fft_valid = fft_valid_q;
  assign frame_err = frame_err_q;

  assign fft_d0  = out_q[0];
  assign fft_d1  = out_q[1];
  assign fft_d2  = out_q[2];
  assign fft_d3  = out_q[3];
  assign fft_d4  = out_q[4];
  assign fft_d5  = out_q[5];
  assign fft_d6  = out_q[6];
  assign fft_d7  = out_q[7];
  assign fft_d8  = out_q[8];
  assign fft_d9  = out_q[9];
  assign fft_d10 = out_q[10];
  assign fft_d11 = out_q[11];
  assign fft_d12 = out_q[12];
  assign fft_d13 = out_q[13];
  assign fft_d14 = out_q[14];
  assign fft_d15 = out_q[15];

endmodule
